hwpe_ctrl_uloop_stepper: RTL and testbench
==========================================

# hwpe_ctrl_uloop_stepper

Sequencer directly downstream of the microcode loop engine (`hwpe_ctrl_uloop`, non-shadowed configuration). On a start pulse it repeatedly steps the loop engine and waits for each fresh set of offsets. It adds the offsets to per-stream base addresses and presents one address tuple per step to the streamers over a valid/ready handshake. It stops after the tuple flagged done and reports completion to the controller FSM.

## Interface
- `NB_REG`, default 4: number of offset registers / address streams.
- `REG_WIDTH`, default 32: width of each loop-engine offset.
- `ADDR_WIDTH`, default 32: width of base and output addresses.
- `LOOP_WIDTH`, default 3: width of the loop index reported per tuple.
- `CNT_WIDTH`, default 16: width of the issued-tuple counter.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `start_i` in 1: single-cycle start pulse.
- `base_addr_i` in NB_REG×ADDR_WIDTH: base addresses, sampled on accepted start.
- `uloop_enable_o` out 1: single-cycle step request to the loop engine (its `ctrl.enable`).
- `uloop_clear_o` out 1: loop engine clear (its `ctrl.clear`).
- `uloop_valid_i` in 1: loop engine flags valid.
- `uloop_done_i` in 1: loop engine done flag.
- `uloop_offs_i` in NB_REG×REG_WIDTH: loop engine offsets.
- `uloop_loop_i` in LOOP_WIDTH: loop engine executed-loop index.
- `stream_valid_o` out 1: address tuple valid.
- `stream_ready_i` in 1: streamers accept the tuple.
- `stream_addr_o` out NB_REG×ADDR_WIDTH: addresses.
- `stream_loop_o` out LOOP_WIDTH: loop index of the tuple.
- `stream_last_o` out 1: tuple is the final one.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: single-cycle completion pulse.
- `count_o` out CNT_WIDTH: tuples accepted since the last accepted start.

## Operation
- FSM states are IDLE, STEP, WAIT, ISSUE and DONE.
- **IDLE**
  - `start_i`=1 samples `base_addr_i` into the base registers, zeroes `count_o`, and moves to STEP.
  - `start_i` is ignored in every other state.
- **STEP**
  - `uloop_enable_o`=1 for exactly this one cycle.
  - Unconditionally moves to WAIT.
- **WAIT**
  - Holds until `uloop_valid_i`=1.
  - On that cycle it captures `stream_addr_o[i] = base[i] + offs[i]`, `stream_loop_o = uloop_loop_i` and `stream_last_o = uloop_done_i`, then moves to ISSUE.
  - Offsets are zero-extended to ADDR_WIDTH when REG_WIDTH<ADDR_WIDTH and truncated when wider.
  - The sum wraps modulo 2^ADDR_WIDTH.
- `uloop_valid_i` outside WAIT is ignored; no capture happens.
- **ISSUE**
  - `stream_valid_o`=1, and the tuple stays stable until the handshake.
  - On `stream_valid_o & stream_ready_i`, `count_o` increments (wrapping at 2^CNT_WIDTH).
  - After the handshake, the next state is DONE if `stream_last_o`=1, otherwise STEP.
- **DONE**
  - `done_o`=1 and `uloop_clear_o`=1 for one cycle, then IDLE.
  - `count_o` and the captured tuple persist until the next accepted start.
- **clear_i**
  - Has priority over every transition.
  - Next state is IDLE, all registers go to reset values, and any pending handshake is dropped.
  - `uloop_clear_o` = `clear_i` OR (state==DONE), driven combinationally.
- **Reset values:** state IDLE; every output 0; base registers 0; `count_o` 0.

## Timing
- Start at cycle 0 gives STEP at cycle 1 (`uloop_enable_o`=1) and WAIT from cycle 2.
- `uloop_valid_i` at cycle k gives `stream_valid_o`=1 from cycle k+1.
- Handshake at cycle h:
  - non-last tuple: `uloop_enable_o`=1 at h+1;
  - last tuple: `done_o`=1 at h+1 and `busy_o`=0 at h+2.
- Minimum period per tuple, with zero-latency loop engine and ready held high: 3 cycles (STEP, WAIT, ISSUE).
- Exactly one step request is ever outstanding.
- `stream_valid_o` never deasserts without a handshake except on `clear_i` or reset.
- All outputs are registered except `uloop_clear_o`.
- Asynchronous reset mid-run returns everything to reset values immediately. No tuple is reissued afterwards.

## Test plan
- **Single tuple, done on first flags:**
  - Stimulus: base={0x1000,0x2000,0x3000,0x4000}; loop engine returns offs={4,8,12,16}, done=1 two cycles after enable; ready tied high.
  - Response: one tuple {0x1004,0x2008,0x300C,0x4010} with last=1; `done_o` pulse; `count_o`=1; `uloop_clear_o` pulse.
- **Five tuples with backpressure:**
  - Stimulus: 5 steps, done on the 5th; ready low for 3 cycles on each tuple.
  - Response: tuple held stable throughout each stall; exactly 5 enables; `count_o`=5; last=1 only on tuple 5.
- **Address wrap:**
  - Stimulus: base=0xFFFF_FFF0, offs=0x20.
  - Response: `stream_addr_o`=0x0000_0010.
- **Spurious inputs:**
  - Stimulus: `uloop_valid_i` pulsed in IDLE and in ISSUE; `start_i` pulsed while busy.
  - Response: no capture, no extra enable, base registers unchanged.
- **Clear mid-run:**
  - Stimulus: `clear_i` asserted in ISSUE with ready low.
  - Response: next cycle IDLE, `stream_valid_o`=0, `count_o`=0; `uloop_clear_o`=1 in the same cycle as `clear_i`.
- **Async reset during WAIT:**
  - Stimulus: `rst_ni` low during WAIT.
  - Response: all outputs 0 immediately; after release, a new start runs a clean 1-tuple sequence.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_stepper.sv
// Steps the microcode loop engine once per tuple, adds the returned offsets to
// the per-stream base addresses and hands each address tuple to the streamers
// over valid/ready. Reports completion once the tuple flagged done is accepted.
module hwpe_ctrl_uloop_stepper #(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LOOP_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [NB_REG*ADDR_WIDTH-1:0]   base_addr_i,
  output logic                           uloop_enable_o,
  output logic                           uloop_clear_o,
  input  logic                           uloop_valid_i,
  input  logic                           uloop_done_i,
  input  logic [NB_REG*REG_WIDTH-1:0]    uloop_offs_i,
  input  logic [LOOP_WIDTH-1:0]          uloop_loop_i,
  output logic                           stream_valid_o,
  input  logic                           stream_ready_i,
  output logic [NB_REG*ADDR_WIDTH-1:0]   stream_addr_o,
  output logic [LOOP_WIDTH-1:0]          stream_loop_o,
  output logic                           stream_last_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [CNT_WIDTH-1:0]           count_o
);

  typedef enum logic [2:0] {StIdle, StStep, StWait, StIssue, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  state_e                         r_state;
  logic [NB_REG*ADDR_WIDTH-1:0]   r_base;
  logic [NB_REG*ADDR_WIDTH-1:0]   r_addr;
  logic [LOOP_WIDTH-1:0]          r_loop;
  logic                           r_last;
  logic                           r_enable;
  logic                           r_valid;
  logic                           r_busy;
  logic                           r_done;
  logic [CNT_WIDTH-1:0]           r_count;

  logic [NB_REG*ADDR_WIDTH-1:0]   w_offs_ext;
  logic [NB_REG*ADDR_WIDTH-1:0]   w_sum;

  // Per-stream offset resize (zero-extend or truncate) and wrapping address sum.
  for (genvar g = 0; g < NB_REG; g++) begin : g_lane
    if (REG_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign w_offs_ext[g*ADDR_WIDTH +: ADDR_WIDTH] = uloop_offs_i[g*REG_WIDTH +: ADDR_WIDTH];
    end else begin : g_zext
      assign w_offs_ext[g*ADDR_WIDTH +: ADDR_WIDTH] =
        {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, uloop_offs_i[g*REG_WIDTH +: REG_WIDTH]};
    end
    assign w_sum[g*ADDR_WIDTH +: ADDR_WIDTH] = r_base[g*ADDR_WIDTH +: ADDR_WIDTH]
                                             + w_offs_ext[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Sequencer FSM; every output except the loop-engine clear is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_base   <= '0;
      r_addr   <= '0;
      r_loop   <= '0;
      r_last   <= 1'b0;
      r_enable <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_state  <= StIdle;
      r_base   <= '0;
      r_addr   <= '0;
      r_loop   <= '0;
      r_last   <= 1'b0;
      r_enable <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      // Enable and done are single-cycle pulses raised only on state entry.
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_base   <= base_addr_i;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_enable <= 1'b1;
            r_state  <= StStep;
          end
        end
        StStep: begin
          r_state <= StWait;
        end
        StWait: begin
          if (uloop_valid_i) begin
            r_addr  <= w_sum;
            r_loop  <= uloop_loop_i;
            r_last  <= uloop_done_i;
            r_valid <= 1'b1;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          if (stream_ready_i) begin
            r_valid <= 1'b0;
            r_count <= r_count + CntOne;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_enable <= 1'b1;
              r_state  <= StStep;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Loop-engine clear follows the soft clear combinationally, plus the DONE pulse.
  always_comb begin
    uloop_clear_o = clear_i | r_done;
  end

  assign uloop_enable_o = r_enable;
  assign stream_valid_o = r_valid;
  assign stream_addr_o  = r_addr;
  assign stream_loop_o  = r_loop;
  assign stream_last_o  = r_last;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign count_o        = r_count;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_stepper.sv
// Bench for hwpe_ctrl_uloop_stepper: directed table of single-tuple runs, hand
// sequences for clear/reset/spurious inputs, and randomized multi-tuple runs
// checked against plain per-lane base+offset arithmetic.
module tb_hwpe_ctrl_uloop_stepper;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic         start_i;
  logic [127:0] base_addr_i;
  logic         uloop_enable_o;
  logic         uloop_clear_o;
  logic         uloop_valid_i;
  logic         uloop_done_i;
  logic [127:0] uloop_offs_i;
  logic [2:0]   uloop_loop_i;
  logic         stream_valid_o;
  logic         stream_ready_i;
  logic [127:0] stream_addr_o;
  logic [2:0]   stream_loop_o;
  logic         stream_last_o;
  logic         busy_o;
  logic         done_o;
  logic [15:0]  count_o;

  int n_vec  = 0;
  int n_fail = 0;
  int en_cnt = 0;

  hwpe_ctrl_uloop_stepper dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .uloop_enable_o (uloop_enable_o),
    .uloop_clear_o  (uloop_clear_o),
    .uloop_valid_i  (uloop_valid_i),
    .uloop_done_i   (uloop_done_i),
    .uloop_offs_i   (uloop_offs_i),
    .uloop_loop_i   (uloop_loop_i),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .stream_addr_o  (stream_addr_o),
    .stream_loop_o  (stream_loop_o),
    .stream_last_o  (stream_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts every step request seen by the loop engine.
  always @(posedge clk_i) if (uloop_enable_o === 1'b1) en_cnt <= en_cnt + 1;

  typedef struct {
    logic [127:0] base;
    logic [127:0] offs;
    logic [127:0] exp_addr;
  } vec_t;

  vec_t vecs[3];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: each 32-bit lane is base + offset, wrapping modulo 2^32.
  function automatic logic [127:0] ref_addr(input logic [127:0] b, input logic [127:0] o);
    logic [127:0] r;
    logic [31:0]  s;
    for (int i = 0; i < 4; i++) begin
      s = b[i*32 +: 32] + o[i*32 +: 32];
      r[i*32 +: 32] = s;
    end
    return r;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_valid"}, stream_valid_o, 1'b0);
    chk({tag, "_enable"}, uloop_enable_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_uclear"}, uloop_clear_o, 1'b0);
  endtask

  // Full run of n tuples from IDLE; lat/stall < 0 means random per tuple.
  task automatic run_seq(input logic [127:0] base, input int n, input int stall, input int lat,
                         input bit fixed, input logic [127:0] f_offs, input logic [127:0] f_exp);
    logic [127:0] offs;
    logic [127:0] exp_a;
    logic [2:0]   lp;
    int           en0;
    int           l;
    int           s;
    base_addr_i = base;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    base_addr_i = rand128();
    en0         = en_cnt;
    for (int t = 0; t < n; t++) begin
      chk("step_enable", uloop_enable_o, 1'b1);
      chk("step_busy", busy_o, 1'b1);
      tick();
      l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      for (int k = 0; k < l; k++) begin
        chk("wait_enable", uloop_enable_o, 1'b0);
        chk("wait_valid", stream_valid_o, 1'b0);
        tick();
      end
      offs  = fixed ? f_offs : rand128();
      exp_a = fixed ? f_exp : ref_addr(base, offs);
      lp    = 3'($urandom);
      uloop_valid_i = 1'b1;
      uloop_offs_i  = offs;
      uloop_loop_i  = lp;
      uloop_done_i  = (t == n - 1);
      tick();
      uloop_valid_i = 1'b0;
      uloop_done_i  = 1'b0;
      uloop_offs_i  = rand128();
      uloop_loop_i  = 3'($urandom);
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int k = 0; k <= s; k++) begin
        chk("issue_valid", stream_valid_o, 1'b1);
        chk("issue_addr", stream_addr_o, exp_a);
        chk("issue_loop", stream_loop_o, lp);
        chk("issue_last", stream_last_o, (t == n - 1));
        chk("issue_enable", uloop_enable_o, 1'b0);
        if (k == s) begin
          stream_ready_i = 1'b1;
        end else if (k == 0) begin
          // Spurious loop-engine flags and start while busy must be ignored.
          uloop_valid_i = 1'b1;
          uloop_done_i  = ~(t == n - 1);
          start_i       = 1'b1;
        end
        tick();
        stream_ready_i = 1'b0;
        uloop_valid_i  = 1'b0;
        uloop_done_i   = 1'b0;
        start_i        = 1'b0;
      end
      chk("count_after_hs", count_o, 16'(t + 1));
    end
    chk("done_pulse", done_o, 1'b1);
    chk("done_uclear", uloop_clear_o, 1'b1);
    chk("done_valid", stream_valid_o, 1'b0);
    chk("done_busy", busy_o, 1'b1);
    tick();
    chk("end_busy", busy_o, 1'b0);
    chk("end_done", done_o, 1'b0);
    chk("end_uclear", uloop_clear_o, 1'b0);
    chk("end_count", count_o, 16'(n));
    chk("end_enables", 128'(en_cnt - en0), 128'(n));
  endtask

  // Start and complete one non-last tuple; leaves the DUT in STEP with count 1.
  task automatic prefix_one_tuple(input logic [127:0] base);
    base_addr_i = base;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    tick();
    uloop_valid_i = 1'b1;
    uloop_offs_i  = rand128();
    uloop_done_i  = 1'b0;
    tick();
    uloop_valid_i  = 1'b0;
    stream_ready_i = 1'b1;
    tick();
    stream_ready_i = 1'b0;
    chk("prefix_count", count_o, 16'd1);
    chk("prefix_enable", uloop_enable_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{base: {32'h4000, 32'h3000, 32'h2000, 32'h1000},
                offs: {32'd16, 32'd12, 32'd8, 32'd4},
                exp_addr: {32'h4010, 32'h300C, 32'h2008, 32'h1004}};
    vecs[1] = '{base: {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0},
                offs: {32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0010, 32'h0000_0020},
                exp_addr: {32'hFFFF_FFEF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0010}};
    vecs[2] = '{base: 128'h0,
                offs: {32'd4, 32'd3, 32'd2, 32'd1},
                exp_addr: {32'd4, 32'd3, 32'd2, 32'd1}};

    rst_ni         = 1'b0;
    clear_i        = 1'b0;
    start_i        = 1'b0;
    base_addr_i    = '0;
    uloop_valid_i  = 1'b0;
    uloop_done_i   = 1'b0;
    uloop_offs_i   = '0;
    uloop_loop_i   = '0;
    stream_ready_i = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_count", count_o, 16'd0);
    chk("reset_addr", stream_addr_o, 128'd0);
    rst_ni = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Spurious loop-engine valid in IDLE: no capture, no busy.
    uloop_valid_i = 1'b1;
    uloop_done_i  = 1'b1;
    uloop_offs_i  = rand128();
    tick();
    uloop_valid_i = 1'b0;
    uloop_done_i  = 1'b0;
    chk_idle_outputs("idle_spurious");
    chk("idle_spurious_addr", stream_addr_o, 128'd0);

    // Directed single-tuple vectors (done returned two cycles after enable).
    for (int v = 0; v < 3; v++) begin
      run_seq(vecs[v].base, 1, 0, 1, 1'b1, vecs[v].offs, vecs[v].exp_addr);
    end

    // Five tuples, three stall cycles on each.
    run_seq(rand128(), 5, 3, 1, 1'b0, '0, '0);

    // Clear in ISSUE with ready low.
    prefix_one_tuple(rand128());
    tick();
    uloop_valid_i = 1'b1;
    tick();
    uloop_valid_i = 1'b0;
    chk("clr_pre_valid", stream_valid_o, 1'b1);
    clear_i = 1'b1;
    #1;
    chk("clr_uclear_comb", uloop_clear_o, 1'b1);
    tick();
    clear_i = 1'b0;
    #1;
    chk_idle_outputs("after_clear");
    chk("after_clear_count", count_o, 16'd0);
    tick();
    chk("after_clear_hold", stream_valid_o, 1'b0);

    // Asynchronous reset during WAIT, then a clean single-tuple run.
    prefix_one_tuple(rand128());
    tick();
    chk("wait_busy", busy_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_count", count_o, 16'd0);
    chk("async_reset_addr", stream_addr_o, 128'd0);
    rst_ni = 1'b1;
    tick();
    chk("post_async_valid", stream_valid_o, 1'b0);
    run_seq(rand128(), 1, 0, 0, 1'b0, '0, '0);

    // Randomized runs against the reference arithmetic.
    for (int r = 0; r < 8; r++) begin
      run_seq(rand128(), int'($urandom_range(1, 6)), -1, -1, 1'b0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
